// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and constants for the convolution sequencer.
package conv_seq_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    CsIdle,
    CsCheck,
    CsRun,
    CsDrain,
    CsDone
  } cs_state_e;

  // Largest supported stride is 1 << MAX_STRIDE_LOG2.
  localparam int unsigned MAX_STRIDE_LOG2 = 3;
  localparam int unsigned STRIDE_W        = $clog2(MAX_STRIDE_LOG2 + 1);

endpackage

// File: rtl/conv_tap_delay.sv
// Enable-gated shift register that aligns tap framing with SRAM read latency.
module conv_tap_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  // Shift one stage per enabled cycle; a stalled cycle leaves every stage untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks pixel -> channel -> kernel row -> kernel col, issuing image and
// weight SRAM reads plus latency-aligned MAC framing and output write addresses.
module conv_seq_ctrl
  import conv_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 13,
  parameter int unsigned MAX_CHANNELS       = 64,
  parameter int unsigned NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1),
  parameter int unsigned SRAM_LAT           = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         img_row_i,
  input  logic [ADDR_WIDTH-1:0]         img_col_i,
  input  logic [ADDR_WIDTH-1:0]         ker_row_i,
  input  logic [ADDR_WIDTH-1:0]         ker_col_i,
  input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels_i,
  input  logic [STRIDE_W-1:0]           stride_log2_i,
  input  logic                          hold_i,
  output logic                          img_rd_en_o,
  output logic [ADDR_WIDTH-1:0]         img_rd_addr_o,
  output logic                          ker_rd_en_o,
  output logic [ADDR_WIDTH-1:0]         ker_rd_addr_o,
  output logic                          mac_en_o,
  output logic                          mac_first_o,
  output logic                          mac_last_o,
  output logic [ADDR_WIDTH-1:0]         out_wr_addr_o,
  output logic [ADDR_WIDTH-1:0]         out_size_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          cfg_err_o
);

  localparam int unsigned AW     = ADDR_WIDTH;
  localparam int unsigned CW     = NUM_CHANNELS_WIDTH;
  localparam int unsigned DrainW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
  localparam int unsigned TapW   = AW + 3;
  localparam logic [AW-1:0] AOne = AW'(1);
  localparam logic [CW-1:0] COne = CW'(1);

  cs_state_e state_q, state_d;

  // Latched metadata.
  logic [AW-1:0]       img_row_q, img_row_d, img_col_q, img_col_d;
  logic [AW-1:0]       ker_row_q, ker_row_d, ker_col_q, ker_col_d;
  logic [CW-1:0]       nch_q, nch_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;

  // Sizes and step values computed once in CHECK.
  logic [AW-1:0] out_rows_q, out_rows_d, out_cols_q, out_cols_d;
  logic [AW-1:0] plane_q, plane_d, row_step_q, row_step_d, col_step_q, col_step_d;
  logic [AW-1:0] out_size_q, out_size_d;

  // Loop counters.
  logic [AW-1:0] kc_q, kc_d, kr_q, kr_d, ocol_q, ocol_d, orow_q, orow_d;
  logic [CW-1:0] ch_q, ch_d;

  // Incremental address components: image address is their sum; the weight address and the
  // output address are plain running counts.
  logic [AW-1:0] ch_base_q, ch_base_d, kr_off_q, kr_off_d;
  logic [AW-1:0] row_base_q, row_base_d, col_base_q, col_base_d;
  logic [AW-1:0] tap_q, tap_d, pix_q, pix_d;

  logic [DrainW-1:0] drain_q, drain_d;
  logic              cfg_err_q, cfg_err_d;

  logic rd_en, cfg_bad;
  logic kc_wrap, kr_wrap, ch_wrap, ocol_wrap, orow_wrap, tap_first, tap_last;
  logic [TapW-1:0] tap_in, tap_out;

  assign kc_wrap   = (kc_q == ker_col_q - AOne);
  assign kr_wrap   = (kr_q == ker_row_q - AOne);
  assign ch_wrap   = (ch_q == nch_q - COne);
  assign ocol_wrap = (ocol_q == out_cols_q - AOne);
  assign orow_wrap = (orow_q == out_rows_q - AOne);
  assign tap_first = (ch_q == '0) && (kr_q == '0) && (kc_q == '0);
  assign tap_last  = kc_wrap && kr_wrap && ch_wrap;

  assign cfg_bad = (img_row_q == '0) || (img_col_q == '0) || (ker_row_q == '0) ||
                   (ker_col_q == '0) || (nch_q == '0) || (ker_row_q > img_row_q) ||
                   (ker_col_q > img_col_q) || (nch_q > CW'(MAX_CHANNELS));

  // State register and all datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= CsIdle;
      img_row_q  <= '0;
      img_col_q  <= '0;
      ker_row_q  <= '0;
      ker_col_q  <= '0;
      nch_q      <= '0;
      stride_q   <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      plane_q    <= '0;
      row_step_q <= '0;
      col_step_q <= '0;
      out_size_q <= '0;
      kc_q       <= '0;
      kr_q       <= '0;
      ch_q       <= '0;
      ocol_q     <= '0;
      orow_q     <= '0;
      ch_base_q  <= '0;
      kr_off_q   <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      tap_q      <= '0;
      pix_q      <= '0;
      drain_q    <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      img_row_q  <= img_row_d;
      img_col_q  <= img_col_d;
      ker_row_q  <= ker_row_d;
      ker_col_q  <= ker_col_d;
      nch_q      <= nch_d;
      stride_q   <= stride_d;
      out_rows_q <= out_rows_d;
      out_cols_q <= out_cols_d;
      plane_q    <= plane_d;
      row_step_q <= row_step_d;
      col_step_q <= col_step_d;
      out_size_q <= out_size_d;
      kc_q       <= kc_d;
      kr_q       <= kr_d;
      ch_q       <= ch_d;
      ocol_q     <= ocol_d;
      orow_q     <= orow_d;
      ch_base_q  <= ch_base_d;
      kr_off_q   <= kr_off_d;
      row_base_q <= row_base_d;
      col_base_q <= col_base_d;
      tap_q      <= tap_d;
      pix_q      <= pix_d;
      drain_q    <= drain_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Next-state logic: metadata capture, one-time sizing, and the nested tap walk.
  always_comb begin
    state_d    = state_q;
    img_row_d  = img_row_q;
    img_col_d  = img_col_q;
    ker_row_d  = ker_row_q;
    ker_col_d  = ker_col_q;
    nch_d      = nch_q;
    stride_d   = stride_q;
    out_rows_d = out_rows_q;
    out_cols_d = out_cols_q;
    plane_d    = plane_q;
    row_step_d = row_step_q;
    col_step_d = col_step_q;
    out_size_d = out_size_q;
    kc_d       = kc_q;
    kr_d       = kr_q;
    ch_d       = ch_q;
    ocol_d     = ocol_q;
    orow_d     = orow_q;
    ch_base_d  = ch_base_q;
    kr_off_d   = kr_off_q;
    row_base_d = row_base_q;
    col_base_d = col_base_q;
    tap_d      = tap_q;
    pix_d      = pix_q;
    drain_d    = drain_q;
    cfg_err_d  = cfg_err_q;
    rd_en      = 1'b0;

    unique case (state_q)
      CsIdle: begin
        if (start_i) begin
          img_row_d = img_row_i;
          img_col_d = img_col_i;
          ker_row_d = ker_row_i;
          ker_col_d = ker_col_i;
          nch_d     = num_channels_i;
          stride_d  = stride_log2_i;
          cfg_err_d = 1'b0;
          state_d   = CsCheck;
        end
      end
      CsCheck: begin
        out_rows_d = ((img_row_q - ker_row_q) >> stride_q) + AOne;
        out_cols_d = ((img_col_q - ker_col_q) >> stride_q) + AOne;
        plane_d    = img_row_q * img_col_q;
        row_step_d = img_col_q << stride_q;
        col_step_d = AOne << stride_q;
        out_size_d = out_rows_d * out_cols_d;
        kc_d       = '0;
        kr_d       = '0;
        ch_d       = '0;
        ocol_d     = '0;
        orow_d     = '0;
        ch_base_d  = '0;
        kr_off_d   = '0;
        row_base_d = '0;
        col_base_d = '0;
        tap_d      = '0;
        pix_d      = '0;
        drain_d    = '0;
        if (cfg_bad) begin
          cfg_err_d = 1'b1;
          state_d   = CsDone;
        end else begin
          state_d = CsRun;
        end
      end
      CsRun: begin
        rd_en = !hold_i;
        if (!hold_i) begin
          tap_d = tap_q + AOne;
          kc_d  = kc_q + AOne;
          if (kc_wrap) begin
            kc_d     = '0;
            kr_d     = kr_q + AOne;
            kr_off_d = kr_off_q + img_col_q;
            if (kr_wrap) begin
              kr_d      = '0;
              kr_off_d  = '0;
              ch_d      = ch_q + COne;
              ch_base_d = ch_base_q + plane_q;
              if (ch_wrap) begin
                ch_d       = '0;
                ch_base_d  = '0;
                tap_d      = '0;
                pix_d      = pix_q + AOne;
                ocol_d     = ocol_q + AOne;
                col_base_d = col_base_q + col_step_q;
                if (ocol_wrap) begin
                  ocol_d     = '0;
                  col_base_d = '0;
                  orow_d     = orow_q + AOne;
                  row_base_d = row_base_q + row_step_q;
                  if (orow_wrap) state_d = CsDrain;
                end
              end
            end
          end
        end
      end
      CsDrain: begin
        // Only unstalled cycles move the delay line, so only they count toward the drain.
        if (!hold_i) begin
          if (drain_q == DrainW'(SRAM_LAT - 1)) begin
            drain_d = '0;
            state_d = CsDone;
          end else begin
            drain_d = drain_q + DrainW'(1);
          end
        end
      end
      CsDone: begin
        state_d = CsIdle;
      end
      default: begin
        state_d = CsIdle;
      end
    endcase
  end

  assign tap_in = {rd_en, rd_en & tap_first, rd_en & tap_last, pix_q};

  conv_tap_delay #(
    .Depth(SRAM_LAT),
    .Width(TapW)
  ) u_tap_delay (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (!hold_i),
    .d_i   (tap_in),
    .q_o   (tap_out)
  );

  // Output decode; framing strobes are masked while stalled so a held event is emitted once.
  always_comb begin
    img_rd_en_o   = rd_en;
    ker_rd_en_o   = rd_en;
    img_rd_addr_o = ch_base_q + row_base_q + kr_off_q + col_base_q + kc_q;
    ker_rd_addr_o = tap_q;
    mac_en_o      = tap_out[TapW-1] & !hold_i;
    mac_first_o   = tap_out[TapW-2] & !hold_i;
    mac_last_o    = tap_out[TapW-3] & !hold_i;
    out_wr_addr_o = tap_out[AW-1:0];
    out_size_o    = out_size_q;
    busy_o        = (state_q == CsCheck) || (state_q == CsRun) || (state_q == CsDrain);
    done_o        = (state_q == CsDone);
    cfg_err_o     = cfg_err_q;
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: directed scenarios plus randomized configurations and
// stalls, checked every cycle against a loop-nest model of the convolution walk.
module tb_conv_seq_ctrl;
  import conv_seq_ctrl_pkg::*;

  localparam int AW   = 13;
  localparam int CW   = 7;
  localparam int MASK = (1 << AW) - 1;

  logic                clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
  logic [AW-1:0]       img_row = '0, img_col = '0, ker_row = '0, ker_col = '0;
  logic [CW-1:0]       nch = '0;
  logic [STRIDE_W-1:0] sl = '0;
  logic                img_rd_en, ker_rd_en, mac_en, mac_first, mac_last, busy, done, cfg_err;
  logic [AW-1:0]       img_rd_addr, ker_rd_addr, out_wr_addr, out_size;

  always #5 clk = ~clk;

  conv_seq_ctrl #(
    .ADDR_WIDTH(AW),
    .MAX_CHANNELS(64),
    .NUM_CHANNELS_WIDTH(CW),
    .SRAM_LAT(1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .img_row_i     (img_row),
    .img_col_i     (img_col),
    .ker_row_i     (ker_row),
    .ker_col_i     (ker_col),
    .num_channels_i(nch),
    .stride_log2_i (sl),
    .hold_i        (hold),
    .img_rd_en_o   (img_rd_en),
    .img_rd_addr_o (img_rd_addr),
    .ker_rd_en_o   (ker_rd_en),
    .ker_rd_addr_o (ker_rd_addr),
    .mac_en_o      (mac_en),
    .mac_first_o   (mac_first),
    .mac_last_o    (mac_last),
    .out_wr_addr_o (out_wr_addr),
    .out_size_o    (out_size),
    .busy_o        (busy),
    .done_o        (done),
    .cfg_err_o     (cfg_err)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: every read the walk must issue, and the MAC event each one must produce.
  typedef struct { int img; int ker; } rd_t;
  typedef struct { bit first; bit last; int oaddr; } mac_t;
  rd_t  rd_q[$];
  mac_t mac_q[$];
  rd_t  cur_rd;
  mac_t cur_mac;
  bit   exp_err;
  int   exp_size;

  task automatic build_model(input int ir, input int ic, input int kr, input int kc,
                             input int c, input int s);
    int st, orr, occ;
    rd_q.delete();
    mac_q.delete();
    exp_err = (ir == 0) || (ic == 0) || (kr == 0) || (kc == 0) || (c == 0) ||
              (kr > ir) || (kc > ic) || (c > 64);
    exp_size = 0;
    if (exp_err) return;
    st  = 1 << s;
    orr = (ir - kr) / st + 1;
    occ = (ic - kc) / st + 1;
    exp_size = (orr * occ) & MASK;
    for (int r = 0; r < orr; r++)
      for (int o = 0; o < occ; o++)
        for (int ch = 0; ch < c; ch++)
          for (int y = 0; y < kr; y++)
            for (int x = 0; x < kc; x++) begin
              rd_t  rd;
              mac_t m;
              rd.img  = (ch * ir * ic + (r * st + y) * ic + o * st + x) & MASK;
              rd.ker  = (ch * kr * kc + y * kc + x) & MASK;
              m.first = (ch == 0) && (y == 0) && (x == 0);
              m.last  = (ch == c - 1) && (y == kr - 1) && (x == kc - 1);
              m.oaddr = (r * occ + o) & MASK;
              rd_q.push_back(rd);
              mac_q.push_back(m);
            end
  endtask

  // Observation log for literal checks.
  int obs_img[$], obs_ker[$], obs_first_pos[$], obs_last_pos[$];
  int reads_seen, macs_seen, done_cnt;
  bit cmp_on = 1'b0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("ker_en_eq_img_en", ker_rd_en, img_rd_en);
      if (hold) check("hold_blocks_rd_and_mac", {img_rd_en, mac_en}, 0);
      if (img_rd_en) begin
        reads_seen++;
        obs_img.push_back(int'(img_rd_addr));
        obs_ker.push_back(int'(ker_rd_addr));
        if (rd_q.size() == 0) check("unexpected_read", 1, 0);
        else begin
          cur_rd = rd_q.pop_front();
          check("img_rd_addr", img_rd_addr, cur_rd.img);
          check("ker_rd_addr", ker_rd_addr, cur_rd.ker);
        end
      end
      if (mac_en) begin
        macs_seen++;
        if (mac_first) obs_first_pos.push_back(macs_seen);
        if (mac_last) obs_last_pos.push_back(macs_seen);
        if (mac_q.size() == 0) check("unexpected_mac", 1, 0);
        else begin
          cur_mac = mac_q.pop_front();
          check("mac_first", mac_first, cur_mac.first);
          check("mac_last", mac_last, cur_mac.last);
          if (cur_mac.last) check("out_wr_addr", out_wr_addr, cur_mac.oaddr);
        end
      end else begin
        check("framing_without_mac_en", {mac_first, mac_last}, 0);
      end
      if (done) done_cnt++;
    end
  end

  // Stall generator: 0 off, 1 random, 2 directed (3 cycles at tap 5, 1 on pixel 0 mac_last).
  int hold_mode = 0, h_left = 0;
  bit h1_done, h2_done;
  always @(posedge clk) begin
    #1;
    if (hold_mode == 1) hold = ($urandom_range(0, 3) == 0);
    else if (hold_mode == 2) begin
      if (h_left > 0) begin
        hold = 1'b1;
        h_left--;
      end else if (reads_seen == 4 && !h1_done) begin
        hold = 1'b1;
        h_left = 2;
        h1_done = 1'b1;
      end else if (reads_seen == 9 && !h2_done) begin
        hold = 1'b1;
        h2_done = 1'b1;
      end else hold = 1'b0;
    end else hold = 1'b0;
  end

  task automatic check_all_zero(input string tag);
    check({tag, " img_rd_en"}, img_rd_en, 0);
    check({tag, " img_rd_addr"}, img_rd_addr, 0);
    check({tag, " ker_rd_en"}, ker_rd_en, 0);
    check({tag, " ker_rd_addr"}, ker_rd_addr, 0);
    check({tag, " mac_en"}, mac_en, 0);
    check({tag, " mac_first"}, mac_first, 0);
    check({tag, " mac_last"}, mac_last, 0);
    check({tag, " out_wr_addr"}, out_wr_addr, 0);
    check({tag, " out_size"}, out_size, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " cfg_err"}, cfg_err, 0);
  endtask

  task automatic clear_obs();
    obs_img.delete();
    obs_ker.delete();
    obs_first_pos.delete();
    obs_last_pos.delete();
    reads_seen = 0;
    macs_seen  = 0;
    done_cnt   = 0;
    h1_done    = 1'b0;
    h2_done    = 1'b0;
    h_left     = 0;
  endtask

  task automatic launch(input int ir, input int ic, input int kr, input int kc, input int c,
                        input int s);
    @(posedge clk);
    #2;
    img_row = AW'(ir);
    img_col = AW'(ic);
    ker_row = AW'(kr);
    ker_col = AW'(kc);
    nch     = CW'(c);
    sl      = STRIDE_W'(s);
    start   = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Runs one job; exp_lat > 0 pins the cycle count from the start edge to the done cycle.
  task automatic run_cfg(input int ir, input int ic, input int kr, input int kc, input int c,
                         input int s, input int hmode, input bit restart, input int exp_lat);
    int lat, n_exp, budget;
    bit seen;
    build_model(ir, ic, kr, kc, c, s);
    clear_obs();
    n_exp     = rd_q.size();
    budget    = 8 * (n_exp + 20);
    hold_mode = hmode;
    launch(ir, ic, kr, kc, c, s);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      #1;
      if (restart && n_exp >= 10 && i == 3) begin
        start   = 1'b1;
        img_row = AW'($urandom);
        ker_row = '0;
        nch     = CW'($urandom);
      end
      if (i == 4) start = 1'b0;
      if (done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    hold_mode = 0;
    check("done_seen", seen, 1);
    if (seen) begin
      if (exp_lat > 0) check("latency", lat, exp_lat);
      check("cfg_err", cfg_err, exp_err);
      if (!exp_err) check("out_size", out_size, exp_size);
      check("reads_issued", reads_seen, n_exp);
      check("reads_left", rd_q.size(), 0);
      check("macs_left", mac_q.size(), 0);
      @(negedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("done_count", done_cnt, 1);
    end
  endtask

  int exp_img9[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int exp_last4[4] = '{9, 18, 27, 36};
  int exp_first4[4] = '{1, 10, 19, 28};

  task automatic check_first_test_shape(input string tag);
    check({tag, " read_count"}, obs_img.size(), 36);
    check({tag, " last_count"}, obs_last_pos.size(), 4);
    check({tag, " first_count"}, obs_first_pos.size(), 4);
    if (obs_img.size() >= 9)
      for (int i = 0; i < 9; i++) begin
        check({tag, " lit_img_addr"}, obs_img[i], exp_img9[i]);
        check({tag, " lit_ker_addr"}, obs_ker[i], i);
      end
    if (obs_last_pos.size() == 4 && obs_first_pos.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check({tag, " lit_last_pos"}, obs_last_pos[i], exp_last4[i]);
        check({tag, " lit_first_pos"}, obs_first_pos[i], exp_first4[i]);
      end
  endtask

  initial begin
    clear_obs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 4x4 image, 3x3 kernel, C=1, S=1.
    run_cfg(4, 4, 3, 3, 1, 0, 0, 1'b0, 39);
    check_first_test_shape("t1");
    check("t1 lit_out_size", out_size, 4);

    // 5x5 image, 3x3 kernel, S=2.
    run_cfg(5, 5, 3, 3, 1, 1, 0, 1'b0, 39);
    if (obs_img.size() == 36) begin
      check("t2 lit_pix1_base", obs_img[9], 2);
      check("t2 lit_pix2_base", obs_img[18], 10);
    end else check("t2 read_count", obs_img.size(), 36);
    check("t2 lit_out_size", out_size, 4);

    // 3x3 image, 2x2 kernel, C=2.
    run_cfg(3, 3, 2, 2, 2, 0, 0, 1'b0, 35);
    check("t3 read_count", obs_img.size(), 32);
    check("t3 last_count", obs_last_pos.size(), 4);
    if (obs_img.size() >= 5) begin
      check("t3 lit_tap5_img", obs_img[4], 9);
      check("t3 lit_tap5_ker", obs_ker[4], 4);
    end

    // First test again with directed stalls: same sequence, four cycles longer.
    run_cfg(4, 4, 3, 3, 1, 0, 2, 1'b0, 43);
    check_first_test_shape("t4");

    // Kernel taller than the image.
    run_cfg(4, 4, 5, 3, 1, 0, 0, 1'b0, 2);
    check("t5 lit_cfg_err", cfg_err, 1);
    check("t5 lit_no_reads", obs_img.size(), 0);

    // 1x1 kernel, C=1: every MAC is both first and last.
    run_cfg(3, 3, 1, 1, 1, 0, 0, 1'b0, 12);
    check("t6 last_count", obs_last_pos.size(), 9);
    check("t6 first_count", obs_first_pos.size(), 9);
    if (obs_last_pos.size() == 9 && obs_first_pos.size() == 9)
      for (int i = 0; i < 9; i++) check("t6 first_eq_last", obs_first_pos[i], obs_last_pos[i]);

    // Reset in the middle of the first test, then a clean rerun.
    build_model(4, 4, 3, 3, 1, 0);
    clear_obs();
    launch(4, 4, 3, 3, 1, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (reads_seen >= 19) break;
    end
    check("t7 reached_tap19", reads_seen, 19);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("t7 midrun_rst");
    check("t7 no_done_on_abort", done_cnt, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rd_q.delete();
    mac_q.delete();
    run_cfg(4, 4, 3, 3, 1, 0, 0, 1'b0, 39);
    check_first_test_shape("t7 rerun");

    // Start together with reset: reset wins.
    rd_q.delete();
    mac_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("t8 rst_wins_busy", busy, 0);
      check("t8 rst_wins_rd_en", img_rd_en, 0);
    end

    // Randomized configurations with random stalls and ignored mid-run starts.
    for (int t = 0; t < 12; t++) begin
      int ir, ic, kr, kc, c, s, kind;
      ir   = $urandom_range(1, 8);
      ic   = $urandom_range(1, 8);
      kr   = $urandom_range(1, ir);
      kc   = $urandom_range(1, ic);
      c    = $urandom_range(1, 3);
      s    = $urandom_range(0, 3);
      kind = $urandom_range(0, 7);
      if (kind == 0) kr = ir + 1;
      else if (kind == 1) c = 0;
      else if (kind == 2) c = 65;
      else if (kind == 3) kc = 0;
      run_cfg(ir, ic, kr, kc, c, s, 1, 1'b1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
